// File: rtl/trace_pkg.sv
// Shared types and helpers for the write-back trace capture path.
package trace_pkg;

    localparam int unsigned TRACE_SEQ_W_DEFAULT = 16;
    localparam int unsigned TRACE_PC_W          = 32;
    localparam int unsigned TRACE_REG_W         = 5;
    localparam int unsigned TRACE_VAL_W         = 32;

    // One retired-instruction trace record ('reg' is a keyword, so the field is rd)
    typedef struct packed {
        logic [TRACE_PC_W-1:0]          pc;
        logic                           ena;
        logic [TRACE_REG_W-1:0]         rd;
        logic [TRACE_VAL_W-1:0]         value;
        logic [TRACE_SEQ_W_DEFAULT-1:0] seq;
    } trace_rec_t;

    // Writes to x0 or with write enable low are recorded as "no write"
    function automatic trace_rec_t trace_normalise(
        input logic [TRACE_PC_W-1:0]          pc,
        input logic                           ena,
        input logic [TRACE_REG_W-1:0]         rd,
        input logic [TRACE_VAL_W-1:0]         value,
        input logic [TRACE_SEQ_W_DEFAULT-1:0] seq
    );
        trace_rec_t r;
        r.pc  = pc;
        r.seq = seq;
        if (ena && (rd != '0)) begin
            r.ena   = 1'b1;
            r.rd    = rd;
            r.value = value;
        end else begin
            r.ena   = 1'b0;
            r.rd    = '0;
            r.value = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records with explicit occupancy count.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  trace_rec_t               din,
    output trace_rec_t               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_rec_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees a slot, so a push into a full FIFO is accepted alongside it
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage: no reset, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retired instructions from the write-back debug ports into a trace stream.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    // Must not exceed TRACE_SEQ_W_DEFAULT, the record's sequence field width
    parameter int unsigned SEQ_W = TRACE_SEQ_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   wb_have_inst,
    input  logic [31:0]            wb_pc,
    input  logic                   wb_ena,
    input  logic [4:0]             wb_reg,
    input  logic [31:0]            wb_value,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic                   trace_ena,
    output logic [4:0]             trace_reg,
    output logic [31:0]            trace_value,
    output logic [SEQ_W-1:0]       trace_seq,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [SEQ_W-1:0]       drop_count
);

    logic       capture;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop;
    logic [SEQ_W-1:0] seq_ctr;
    trace_rec_t rec_in;
    trace_rec_t rec_head;

    assign capture     = enable && wb_have_inst;
    assign trace_valid = !fifo_empty;
    assign pop         = trace_valid && trace_ready;
    // Full with no pop in the same cycle: the record is lost; clear discards silently
    assign drop        = capture && !clear && fifo_full && !pop;
    assign rec_in      = trace_normalise(wb_pc, wb_ena, wb_reg, wb_value,
                                         TRACE_SEQ_W_DEFAULT'(seq_ctr));

    // Head record fields; the FIFO already zeroes them when empty
    assign trace_pc    = rec_head.pc;
    assign trace_ena   = rec_head.ena;
    assign trace_reg   = rec_head.rd;
    assign trace_value = rec_head.value;
    assign trace_seq   = SEQ_W'(rec_head.seq);

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (capture),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequence counter advances on every capture, dropped or not, so gaps are visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_ctr <= '0;
        end else if (clear) begin
            seq_ctr <= '0;
        end else if (capture) begin
            seq_ctr <= seq_ctr + SEQ_W'(1);
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + SEQ_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=16, SEQ_W=16).
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        wb_have_inst;
    logic [31:0] wb_pc;
    logic        wb_ena;
    logic [4:0]  wb_reg;
    logic [31:0] wb_value;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic        trace_ena;
    logic [4:0]  trace_reg;
    logic [31:0] trace_value;
    logic [15:0] trace_seq;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    wb_trace_buffer #(.DEPTH(16), .SEQ_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .wb_have_inst (wb_have_inst),
        .wb_pc        (wb_pc),
        .wb_ena       (wb_ena),
        .wb_reg       (wb_reg),
        .wb_value     (wb_value),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_ena    (trace_ena),
        .trace_reg    (trace_reg),
        .trace_value  (trace_value),
        .trace_seq    (trace_seq),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cap(input logic have, input logic [31:0] pc, input logic ena,
                           input logic [4:0] rd, input logic [31:0] val);
        wb_have_inst = have;
        wb_pc        = pc;
        wb_ena       = ena;
        wb_reg       = rd;
        wb_value     = val;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; trace_ready = 1'b0;
        set_cap(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(); step();
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf",   64'(overflow),   64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);
        chk("rst_pc",    64'(trace_pc),   64'd0);
        rst = 1'b0;
        step();

        // Three captures then drain
        set_cap(1'b1, 32'h0, 1'b1, 5'd5, 32'h11);
        step();
        chk("cap1_valid", 64'(trace_valid), 64'd1);
        chk("cap1_count", 64'(fifo_count),  64'd1);
        set_cap(1'b1, 32'h4, 1'b1, 5'd5, 32'h22);
        step();
        set_cap(1'b1, 32'h8, 1'b1, 5'd5, 32'h33);
        step();
        wb_have_inst = 1'b0;
        chk("cap3_count", 64'(fifo_count), 64'd3);
        trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_pc",    64'(trace_pc),    64'(4 * i));
            chk("drain_value", 64'(trace_value), 64'(32'h11 * (i + 1)));
            chk("drain_seq",   64'(trace_seq),   64'(i));
            chk("drain_reg",   64'(trace_reg),   64'd5);
            chk("drain_ena",   64'(trace_ena),   64'd1);
            step();
        end
        chk("drain_count", 64'(fifo_count), 64'd0);
        chk("drain_valid", 64'(trace_valid), 64'd0);
        chk("drain_pc0",   64'(trace_pc),    64'd0);

        // Normalisation: write to x0
        trace_ready = 1'b0;
        set_cap(1'b1, 32'h100, 1'b1, 5'd0, 32'hDEAD);
        step();
        wb_have_inst = 1'b0;
        chk("norm_ena",   64'(trace_ena),   64'd0);
        chk("norm_reg",   64'(trace_reg),   64'd0);
        chk("norm_value", 64'(trace_value), 64'd0);
        chk("norm_pc",    64'(trace_pc),    64'h100);
        chk("norm_seq",   64'(trace_seq),   64'd3);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;

        // Overflow: clear, then 18 captures with no consumer
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_cap(1'b1, 32'(4 * i), 1'b1, 5'd7, 32'(i));
            step();
        end
        wb_have_inst = 1'b0;
        chk("ovf_count", 64'(fifo_count), 64'd16);
        chk("ovf_flag",  64'(overflow),   64'd1);
        chk("ovf_drop",  64'(drop_count), 64'd2);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_seq", 64'(trace_seq), 64'(i));
            step();
        end
        trace_ready = 1'b0;
        chk("ovf_empty", 64'(fifo_count), 64'd0);
        set_cap(1'b1, 32'h500, 1'b1, 5'd7, 32'h1);
        step();
        wb_have_inst = 1'b0;
        chk("ovf_next_seq", 64'(trace_seq), 64'd18);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;

        // Full push with pop: seqs 19..34 fill, capture seq 35 with a pop
        for (int i = 0; i < 16; i++) begin
            set_cap(1'b1, 32'(32'h600 + 4 * i), 1'b1, 5'd3, 32'(i));
            step();
        end
        chk("full_count", 64'(fifo_count), 64'd16);
        set_cap(1'b1, 32'hABC, 1'b1, 5'd3, 32'h77);
        trace_ready = 1'b1;
        step();
        wb_have_inst = 1'b0;
        chk("fpp_count", 64'(fifo_count), 64'd16);
        chk("fpp_drop",  64'(drop_count), 64'd2);
        for (int i = 0; i < 15; i++) begin
            chk("fpp_seq", 64'(trace_seq), 64'(20 + i));
            step();
        end
        chk("fpp_tail_pc",  64'(trace_pc),    64'hABC);
        chk("fpp_tail_seq", 64'(trace_seq),   64'd35);
        chk("fpp_tail_val", 64'(trace_value), 64'h77);
        step();
        chk("fpp_empty", 64'(fifo_count), 64'd0);
        trace_ready = 1'b0;

        // Clear together with a capture, FIFO full and overflow set
        for (int i = 0; i < 16; i++) begin
            set_cap(1'b1, 32'(4 * i), 1'b1, 5'd1, 32'(i));
            step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        wb_have_inst = 1'b0;
        chk("clr_count", 64'(fifo_count),  64'd0);
        chk("clr_valid", 64'(trace_valid), 64'd0);
        chk("clr_ovf",   64'(overflow),    64'd0);
        chk("clr_drop",  64'(drop_count),  64'd0);
        set_cap(1'b1, 32'h900, 1'b1, 5'd2, 32'h5);
        step();
        wb_have_inst = 1'b0;
        chk("clr_seq0", 64'(trace_seq), 64'd0);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;

        // Enable low: commits ignored, seq unchanged
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cap(1'b1, 32'(32'hA00 + 4 * i), 1'b1, 5'd4, 32'(i));
            step();
        end
        chk("dis_count", 64'(fifo_count),  64'd0);
        chk("dis_valid", 64'(trace_valid), 64'd0);
        enable = 1'b1;
        set_cap(1'b1, 32'hB00, 1'b1, 5'd4, 32'h9);
        step();
        wb_have_inst = 1'b0;
        chk("dis_seq", 64'(trace_seq), 64'd1);
        chk("dis_pc",  64'(trace_pc),  64'hB00);

        // Async reset mid-drain: 5 queued, one popped -> 4 left
        for (int i = 0; i < 4; i++) begin
            set_cap(1'b1, 32'(32'hC00 + 4 * i), 1'b1, 5'd6, 32'(i));
            step();
        end
        wb_have_inst = 1'b0;
        trace_ready  = 1'b1;
        step();
        chk("ar_pre_count", 64'(fifo_count), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(trace_valid), 64'd0);
        chk("ar_count", 64'(fifo_count),  64'd0);
        chk("ar_pc",    64'(trace_pc),    64'd0);
        step();
        rst = 1'b0;
        trace_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Captures every retired instruction reported on the core's write-back debug ports and queues it as a trace record for a host-side consumer. It sits directly downstream of the core's `debug_wb_*` outputs, inside the trace-test harness. Records leave through a valid/ready stream. Overflow is counted and reported, never stalls the core, and leaves a visible gap in the sequence number.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `SEQ_W`, 16: width of sequence number and drop counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: capture enable; when 0, commits are ignored and not counted.
- `clear` in 1: synchronous clear of buffer and status.
- `wb_have_inst` in 1: a retired instruction is present this cycle.
- `wb_pc` in 32: PC of the retired instruction.
- `wb_ena` in 1: register write enable.
- `wb_reg` in 5: destination register.
- `wb_value` in 32: write-back value.
- `trace_valid` out 1: a record is available at the head of the FIFO.
- `trace_ready` in 1: the consumer accepts the head record.
- `trace_pc` out 32: head record PC.
- `trace_ena` out 1: head record write enable.
- `trace_reg` out 5: head record destination register.
- `trace_value` out 32: head record write-back value.
- `trace_seq` out SEQ_W: head record sequence number.
- `fifo_count` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag; set when any record has been dropped.
- `drop_count` out SEQ_W: number of dropped records; saturates at all-ones.

## Operation
- Capture event is `enable && wb_have_inst`, sampled at the rising edge of `clk`.
- Record normalisation:
  - If `wb_ena==0` or `wb_reg==0`, the record stores `ena=0`, `reg=0`, `value=0`.
  - Otherwise the inputs are stored verbatim.
  - `pc` is always stored verbatim.
- Sequence numbering:
  - An internal `seq_ctr` is stamped into each captured record.
  - `seq_ctr` increments on every capture event, including dropped ones, so the consumer sees gaps.
  - It wraps modulo 2^SEQ_W.
- Push: a capture event is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Drop: a capture event with the FIFO full and no pop.
  - Record discarded.
  - `overflow` set.
  - `drop_count` incremented; it saturates and does not wrap.
- Pop: `trace_valid && trace_ready`. It advances the read pointer.
- `trace_valid` equals `fifo_count != 0`.
- Output fields:
  - The FIFO is first-word-fall-through: `trace_*` fields show the head entry whenever `trace_valid` is high.
  - While `trace_valid` is low, the fields hold 0.
- Pointers are clog2(DEPTH) bits wide and wrap naturally. Occupancy is tracked by the explicit `fifo_count` register.
- Simultaneous push and pop:
  - When not empty, `fifo_count` is unchanged.
  - When empty, only the push happens, because there is no valid head to pop.
- `clear` takes priority over push and pop in its cycle. It zeroes:
  - both pointers and `fifo_count`;
  - `seq_ctr`, `overflow` and `drop_count`.

  A capture event in the same cycle as `clear` is discarded and does not count as a drop.
- `enable` low: no pushes. Pops continue, so the FIFO drains.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0, including `trace_valid`.
  - Pointers, `fifo_count`, `seq_ctr`, `overflow` and `drop_count` are 0.
  - Storage contents are don't-care.
- Latency: a capture at edge N raises `trace_valid` after edge N when the FIFO was empty. The record is visible for the cycle following capture.
- A pop at edge N presents the next head entry (or deasserts `trace_valid`) after edge N.
- Throughput: one push and one pop per cycle, sustained.
- `fifo_count`, `overflow` and `drop_count` update on the same edge as the push, pop or drop that changes them.
- Reset asserted mid-stream discards all contents immediately. There is no partial record.

## Structure
- Shared package `trace_pkg` contains:
  - record struct `trace_rec_t {pc[31:0], ena, reg[4:0], value[31:0], seq[SEQ_W-1:0]}`;
  - the normalisation function;
  - constant `TRACE_SEQ_W_DEFAULT = 16`.
- One sub-module, `trace_fifo`: a generic FWFT FIFO of `trace_rec_t` with push, pop, clear, count and full/empty.
- The top level holds capture qualification, `seq_ctr` and the drop/overflow logic.

## Test plan
- Reset, then three captures, then drain:
  - Stimulus: PCs 0x0, 0x4, 0x8 with values 0x11, 0x22, 0x33 to reg 5; `trace_ready=1` after capture.
  - Expect: three records in order with `seq` 0, 1, 2; `fifo_count` back to 0.
- Normalisation:
  - Stimulus: capture with `wb_reg=0`, `wb_ena=1`, `wb_value=0xDEAD`.
  - Expect: record `ena=0`, `reg=0`, `value=0`.
- Overflow at DEPTH=16:
  - Stimulus: 18 captures with `trace_ready=0`.
  - Expect:
    - `fifo_count=16`, `overflow=1`, `drop_count=2`;
    - drained `seq` values are 0–15;
    - the next accepted capture carries `seq=18`.
- Full push with pop:
  - Stimulus: FIFO full, capture with `trace_ready=1` in the same cycle.
  - Expect: no drop, `fifo_count` stays 16, new record at the tail.
- Clear and enable:
  - Stimulus: `clear` together with a capture.
  - Expect: all status 0, record discarded, `drop_count=0`.
  - Stimulus: `enable=0` with 5 commits.
  - Expect: no records and `seq` unchanged.
- Asynchronous reset mid-drain:
  - Stimulus: assert `rst` between edges with `fifo_count=4`.
  - Expect: `trace_valid=0` and `fifo_count=0` before the next edge.
